// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-memory write-side loader.
package instr_mem_pkg;

    // Each instruction word is split into this many byte writes.
    localparam int BYTES_PER_WORD = 4;

    // Loader session states.
    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: accepts 32-bit words over a valid/ready stream
// and writes each one as four MSB-first byte writes to consecutive
// addresses. busy doubles as the core reset-hold while a program is loaded.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int A_WIDTH = 20,
    parameter int D_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [A_WIDTH-1:0]          base_addr,
    input  logic [A_WIDTH-1:0]          word_count,
    input  logic                        s_valid,
    input  logic [BYTES_PER_WORD*D_WIDTH-1:0] s_data,
    output logic                        s_ready,
    output logic                        we,
    output logic [A_WIDTH-1:0]          wa,
    output logic [D_WIDTH-1:0]          wd,
    output logic                        busy,
    output logic                        done
);

    localparam int W_WIDTH = BYTES_PER_WORD * D_WIDTH;
    localparam int IDX_W   = $clog2(BYTES_PER_WORD);

    loader_state_t      r_state;
    logic [A_WIDTH-1:0] r_addr;
    logic [A_WIDTH-1:0] r_remaining;
    logic [W_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic               r_s_ready;
    logic               r_we;
    logic [A_WIDTH-1:0] r_wa;
    logic [D_WIDTH-1:0] r_wd;
    logic               r_busy;
    logic               r_done;

    logic               w_last_byte;
    logic [IDX_W-1:0]   w_next_idx;
    logic [A_WIDTH-1:0] w_next_wa;

    // r_idx is the byte currently on the write port; the registered outputs
    // for the next byte are prepared one cycle ahead so every output comes
    // straight from a flop.
    assign w_last_byte = (r_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign w_next_idx  = r_idx + IDX_W'(1);
    // Address arithmetic wraps naturally at the A_WIDTH boundary, even
    // within one word.
    assign w_next_wa   = r_addr + A_WIDTH'(w_next_idx);

    // Session FSM with byte counter, shift register and registered outputs.
    // NOTE: every flop here uses <= so all state updates see the values from
    // before the edge; mixing in = would make results depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_shift     <= '0;
            r_idx       <= '0;
            r_s_ready   <= 1'b0;
            r_we        <= 1'b0;
            r_wa        <= '0;
            r_wd        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        if (word_count != '0) begin
                            r_addr      <= base_addr;
                            r_remaining <= word_count;
                            r_s_ready   <= 1'b1;
                            r_state     <= RECV;
                        end else begin
                            // Empty session: report completion without writing.
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end

                RECV: begin
                    // s_ready is always high in this state, so s_valid alone
                    // completes the handshake.
                    if (s_valid) begin
                        r_s_ready <= 1'b0;
                        r_we      <= 1'b1;
                        r_wa      <= r_addr;
                        r_wd      <= s_data[W_WIDTH-1 -: D_WIDTH];
                        r_shift   <= s_data << D_WIDTH;
                        r_idx     <= '0;
                        r_state   <= WRITE;
                    end
                end

                WRITE: begin
                    if (w_last_byte) begin
                        r_we        <= 1'b0;
                        r_addr      <= r_addr + A_WIDTH'(BYTES_PER_WORD);
                        r_remaining <= r_remaining - A_WIDTH'(1);
                        if (r_remaining == A_WIDTH'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_s_ready <= 1'b1;
                            r_state   <= RECV;
                        end
                    end else begin
                        r_wa    <= w_next_wa;
                        r_wd    <= r_shift[W_WIDTH-1 -: D_WIDTH];
                        r_shift <= r_shift << D_WIDTH;
                        r_idx   <= w_next_idx;
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign we      = r_we;
    assign wa      = r_wa;
    assign wd      = r_wd;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
